// File: rtl/m_serial_shifter.sv
// m_serial_shifter: bit-serial SLL/SRL/SRA datapath with start/busy/done handshake.
// Loads an operand and a shift amount, then shifts one position per clock
// until the remaining count reaches zero.
// Optional build macro SERIAL_SHIFTER_NIBBLE_EN: while at least four positions
// remain, shift four positions per clock instead of one.
// XLEN must equal 2**SHW so that any shift amount fits the count register.
module m_serial_shifter #(
    parameter int XLEN = 32,
    parameter int SHW  = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] din,
    input  logic [SHW-1:0]  shamt,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] dout,
    output logic [SHW-1:0]  dbg_cnt
);

    // Controller states
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_SHIFT = 2'b01;
    localparam logic [1:0] ST_DONE  = 2'b10;

    // Operation codes; 01 and the reserved 11 both decode to SRL
    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b10;

    localparam logic [SHW-1:0] CNT_ONE = SHW'(1);
`ifdef SERIAL_SHIFTER_NIBBLE_EN
    localparam logic [SHW-1:0] CNT_FOUR = SHW'(4);
`endif

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] dout_q,  dout_d;
    logic [SHW-1:0]  cnt_q,   cnt_d;
    logic [1:0]      op_q,    op_d;

    // Single-position step; any code other than SLL/SRA is a logical right shift
    function automatic logic [XLEN-1:0] step1(input logic [XLEN-1:0] v,
                                              input logic [1:0]      o);
        logic [XLEN-1:0] r;
        case (o)
            OP_SLL:  r = {v[XLEN-2:0], 1'b0};
            OP_SRA:  r = {v[XLEN-1], v[XLEN-1:1]};
            default: r = {1'b0, v[XLEN-1:1]};
        endcase
        return r;
    endfunction

`ifdef SERIAL_SHIFTER_NIBBLE_EN
    // Four-position step with the same semantics; SRA replicates the sign bit four times
    function automatic logic [XLEN-1:0] step4(input logic [XLEN-1:0] v,
                                              input logic [1:0]      o);
        logic [XLEN-1:0] r;
        case (o)
            OP_SLL:  r = {v[XLEN-5:0], 4'b0000};
            OP_SRA:  r = {{4{v[XLEN-1]}}, v[XLEN-1:4]};
            default: r = {4'b0000, v[XLEN-1:4]};
        endcase
        return r;
    endfunction
`endif

    // Next-state and datapath update for the load/shift/done sequence
    always_comb begin
        state_d = state_q;
        dout_d  = dout_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        case (state_q)
            ST_IDLE: begin
                // Operands are only sampled here; a zero amount goes straight to DONE
                if (start) begin
                    dout_d  = din;
                    cnt_d   = shamt;
                    op_d    = op;
                    state_d = (shamt != '0) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
`ifdef SERIAL_SHIFTER_NIBBLE_EN
                if (cnt_q >= CNT_FOUR) begin
                    dout_d = step4(dout_q, op_q);
                    cnt_d  = cnt_q - CNT_FOUR;
                    if (cnt_q == CNT_FOUR) begin
                        state_d = ST_DONE;
                    end
                end else
`endif
                begin
                    // The count is never decremented below zero; a zero count
                    // in SHIFT (unreachable in normal use) simply finishes.
                    if (cnt_q != '0) begin
                        dout_d = step1(dout_q, op_q);
                        cnt_d  = cnt_q - CNT_ONE;
                    end
                    if (cnt_q <= CNT_ONE) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // Start is ignored here; result is held until the next accepted start
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any operation in flight without a done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            dout_q  <= '0;
            cnt_q   <= '0;
            op_q    <= 2'b00;
        end else begin
            state_q <= state_d;
            dout_q  <= dout_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

    // Handshake outputs decode directly from the registered state
    assign busy    = (state_q == ST_SHIFT);
    assign done    = (state_q == ST_DONE);
    assign dout    = dout_q;
    assign dbg_cnt = cnt_q;

endmodule

// File: tb/tb_m_serial_shifter.sv
// Self-checking bench for m_serial_shifter: directed vector table, hand-written
// corner sequences (ignored start, reset mid-operation) and randomized
// operations against an arithmetic reference model.
module tb_m_serial_shifter;

    localparam int XLEN = 32;
    localparam int SHW  = 5;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] din;
    logic [SHW-1:0]  shamt;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] dout;
    logic [SHW-1:0]  dbg_cnt;

    int total = 0;
    int bad   = 0;

    m_serial_shifter #(.XLEN(XLEN), .SHW(SHW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .din     (din),
        .shamt   (shamt),
        .busy    (busy),
        .done    (done),
        .dout    (dout),
        .dbg_cnt (dbg_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]      op;
        logic [XLEN-1:0] din;
        logic [SHW-1:0]  shamt;
        logic [XLEN-1:0] exp_dout;
    } vec_t;

    // Reference result straight from the shift definitions
    function automatic logic [XLEN-1:0] ref_shift(input logic [1:0] o,
                                                  input logic [XLEN-1:0] d,
                                                  input int s);
        logic signed [XLEN-1:0] sd;
        sd = d;
        if (o == 2'b00)      return d << s;
        else if (o == 2'b10) return XLEN'(sd >>> s);
        else                 return d >> s;
    endfunction

    // Reference cycle in which done appears (start cycle is cycle 0)
    function automatic int ref_lat(input int s);
`ifdef SERIAL_SHIFTER_NIBBLE_EN
        return s / 4 + s % 4 + 1;
`else
        return s + 1;
`endif
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation right now and follow it to completion plus one cycle
    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [XLEN-1:0] d, input logic [SHW-1:0] s,
                          input logic [XLEN-1:0] exp_dout);
        int cyc;
        int busy_cnt;
        int done_cyc;
        logic [XLEN-1:0] got;
        int lat;
        lat      = ref_lat(int'(s));
        start    = 1'b1;
        op       = o;
        din      = d;
        shamt    = s;
        tick();
        start    = 1'b0;
        op       = 2'($urandom);
        din      = $urandom;
        shamt    = SHW'($urandom);
        cyc      = 1;
        busy_cnt = 0;
        done_cyc = -1;
        got      = '0;
        check({tag, " cnt@1"}, longint'(dbg_cnt),
              (s == 0) ? 64'd0 : longint'(s));
        while (cyc <= 60) begin
            if (done) begin
                done_cyc = cyc;
                got      = dout;
                check({tag, " busy@done"}, longint'(busy), 0);
                check({tag, " cnt@done"}, longint'(dbg_cnt), 0);
                break;
            end
            if (busy) busy_cnt++;
            tick();
            cyc++;
        end
        check({tag, " done_cycle"}, longint'(done_cyc), longint'(lat));
        check({tag, " dout"}, longint'(got), longint'(exp_dout));
        check({tag, " busy_cycles"}, longint'(busy_cnt), longint'(lat - 1));
        tick();
        check({tag, " done_pulse"}, longint'(done), 0);
        check({tag, " dout_hold"}, longint'(dout), longint'(exp_dout));
    endtask

    vec_t vecs[8];

    initial begin
        int n_done;
        int dcyc;

        start = 1'b0;
        op    = 2'b00;
        din   = '0;
        shamt = '0;
        rst_n = 1'b0;

        // Reset, then idle with no start
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("reset dout", longint'(dout), 0);
        check("reset busy", longint'(busy), 0);
        check("reset done", longint'(done), 0);
        check("reset cnt", longint'(dbg_cnt), 0);
        n_done = 0;
        repeat (6) begin
            tick();
            if (done || busy) n_done++;
        end
        check("idle no activity", longint'(n_done), 0);

        // Directed vectors (run back to back)
        vecs[0] = '{2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000};
        vecs[1] = '{2'b10, 32'h8000_00F0, 5'd4,  32'hF800_000F};
        vecs[2] = '{2'b01, 32'h8000_00F0, 5'd4,  32'h0800_000F};
        vecs[3] = '{2'b10, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
        vecs[4] = '{2'b11, 32'hF000_0000, 5'd28, 32'h0000_000F};
        vecs[5] = '{2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF};
        vecs[6] = '{2'b10, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000};
        vecs[7] = '{2'b00, 32'hFFFF_FFFF, 5'd5,  32'hFFFF_FFE0};
        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].din,
                   vecs[i].shamt, vecs[i].exp_dout);
        end

        // Start re-issued while busy/done must be ignored
        start = 1'b1; op = 2'b00; din = 32'h0000_00FF; shamt = 5'd8;
        tick();
        start = 1'b0;
        n_done = 0;
        dcyc   = -1;
        for (int c = 1; c <= 15; c++) begin
            if (c == 3) begin
                start = 1'b1; din = '0; shamt = 5'd1; op = 2'b01;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                n_done++;
                if (dcyc < 0) begin
                    dcyc = c;
                    check("ignored_start dout", longint'(dout), 64'h0000_FF00);
                end
            end
            tick();
        end
        check("ignored_start done_count", longint'(n_done), 1);
        check("ignored_start done_cycle", longint'(dcyc), longint'(ref_lat(8)));

        // Reset in the middle of an operation
        start = 1'b1; op = 2'b00; din = 32'h1234_5678; shamt = 5'd20;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        check("midreset dout", longint'(dout), 0);
        check("midreset busy", longint'(busy), 0);
        check("midreset cnt", longint'(dbg_cnt), 0);
        n_done = 0;
        repeat (3) begin
            tick();
            if (done) n_done++;
        end
        rst_n = 1'b1;
        repeat (25) begin
            tick();
            if (done || busy) n_done++;
        end
        check("midreset no_done", longint'(n_done), 0);
        run_op("after_reset", 2'b01, 32'h0000_0002, 5'd1, 32'h0000_0001);

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            logic [1:0]      ro;
            logic [XLEN-1:0] rd;
            logic [SHW-1:0]  rs;
            ro = 2'($urandom);
            rd = $urandom;
            rs = SHW'($urandom_range(0, XLEN - 1));
            run_op($sformatf("rand%0d", i), ro, rd, rs, ref_shift(ro, rd, int'(rs)));
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
